// File: rtl/mini_stim_gen.sv
// mini_stim_gen: burst stimulus source (LFSR / counter / walking-one / constant) on valid/ready.
// Define MINI_STIM_CHECKSUM_EN to build the XOR checksum of accepted beats; otherwise o_csum is 0.
module mini_stim_gen #(
    parameter int unsigned DW   = 16,
    parameter int unsigned LW   = 16,
    parameter logic [31:0] SEED = 32'h0000_ACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [1:0]    i_mode,
    input  logic [LW-1:0] i_len,
    input  logic [DW-1:0] i_const,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [LW-1:0] o_cnt,
    output logic [DW-1:0] o_csum
);

    localparam logic [1:0] ModeLfsr  = 2'd0;
    localparam logic [1:0] ModeCount = 2'd1;
    localparam logic [1:0] ModeWalk  = 2'd2;
    localparam logic [1:0] ModeConst = 2'd3;

    localparam logic [DW-1:0] SeedRaw  = DW'(SEED);
    localparam logic [DW-1:0] SeedInit = (SeedRaw == '0) ? DW'(1) : SeedRaw;

    // Feedback tap masks: DW=8 {0,2,3,4}, DW=16 {0,2,3,5}, DW=32 {0,10,30,31}.
    localparam logic [31:0] TapMask32 = (DW == 8)  ? 32'h0000_001D :
                                        (DW == 16) ? 32'h0000_002D :
                                                     32'hC000_0401;
    localparam logic [DW-1:0] TapMask = DW'(TapMask32);

    if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_dw_check
        $error("mini_stim_gen: LFSR supports DW of 8, 16 or 32 only");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] gen_q, gen_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    logic [DW-1:0] gen_init;
    logic [DW-1:0] gen_next;
    logic [LW-1:0] cnt_inc;
    logic          lfsr_fb;
    logic          accept;
    logic          load;

    assign cnt_inc = cnt_q + LW'(1);
    assign lfsr_fb = ^(gen_q & TapMask);

    always_comb begin
        gen_init = '0;
        unique case (i_mode)
            ModeLfsr:  gen_init = SeedInit;
            ModeCount: gen_init = '0;
            ModeWalk:  gen_init = DW'(1);
            ModeConst: gen_init = i_const;
        endcase
    end

    always_comb begin
        gen_next = gen_q;
        unique case (mode_q)
            ModeLfsr:  gen_next = {lfsr_fb, gen_q[DW-1:1]};
            ModeCount: gen_next = gen_q + DW'(1);
            ModeWalk:  gen_next = {gen_q[DW-2:0], gen_q[DW-1]};
            ModeConst: gen_next = gen_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        gen_d   = gen_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRun;
                    load    = 1'b1;
                    mode_d  = i_mode;
                    len_d   = i_len;
                    cnt_d   = '0;
                    gen_d   = gen_init;
                end
            end
            StRun: begin
                accept = run_q & i_ready;
                if (accept) begin
                    gen_d = gen_next;
                    cnt_d = cnt_inc;
                end
                // A beat accepted alongside i_stop is still counted above.
                if ((accept && (len_q != '0) && (cnt_inc == len_q)) || i_stop) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        run_d  = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeLfsr;
            len_q   <= '0;
            gen_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            gen_q   <= gen_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

`ifdef MINI_STIM_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q ^ gen_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign o_csum = csum_q;
`else
    assign o_csum = '0;
`endif

    assign o_valid = run_q;
    assign o_busy  = run_q;
    assign o_done  = done_q;
    assign o_data  = gen_q;
    assign o_cnt   = cnt_q;

    a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !i_ready) |=> $stable(o_data));

    a_done_single : assert property (@(posedge clk) disable iff (!rst_n)
        o_done |=> !o_done);

endmodule

// File: tb/tb_mini_stim_gen.sv
// Self-checking bench for mini_stim_gen: directed and randomized bursts checked against a
// word-index reference model (k-th word of a burst computed directly from the generator rules).
module tb_mini_stim_gen;

    localparam int unsigned DW  = 16;
    localparam int unsigned LW  = 16;
    localparam int unsigned DW8 = 8;
    localparam int unsigned LW8 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start, stop, ready, valid, busy, done;
    logic [1:0]    mode;
    logic [LW-1:0] len, cnt;
    logic [DW-1:0] cval, data, csum;

    logic           start8, stop8, ready8, valid8, busy8, done8;
    logic [1:0]     mode8;
    logic [LW8-1:0] len8, cnt8;
    logic [DW8-1:0] cval8, data8, csum8;

    int total = 0;
    int bad   = 0;
    int pat[$];

    mini_stim_gen #(.DW(DW), .LW(LW), .SEED(32'h0000_ACE1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop), .i_mode(mode),
        .i_len(len), .i_const(cval), .o_valid(valid), .i_ready(ready), .o_data(data),
        .o_busy(busy), .o_done(done), .o_cnt(cnt), .o_csum(csum)
    );

    mini_stim_gen #(.DW(DW8), .LW(LW8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start8), .i_stop(stop8), .i_mode(mode8),
        .i_len(len8), .i_const(cval8), .o_valid(valid8), .i_ready(ready8), .o_data(data8),
        .o_busy(busy8), .o_done(done8), .o_cnt(cnt8), .o_csum(csum8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int dw);
        return (64'd1 << dw) - 64'd1;
    endfunction

    // k-th word of a burst, derived from the generator rules rather than a running state.
    function automatic logic [63:0] ref_word(input int dw, input int m, input int k,
                                             input logic [63:0] c);
        logic [63:0] s;
        logic        fb;
        int          taps[4];
        if (m == 1) return 64'(unsigned'(k)) & mask_of(dw);
        if (m == 2) return 64'd1 << (k % dw);
        if (m == 3) return c & mask_of(dw);
        if (dw == 8)       taps = '{0, 2, 3, 4};
        else if (dw == 16) taps = '{0, 2, 3, 5};
        else               taps = '{0, 10, 30, 31};
        s = 64'h0000_ACE1 & mask_of(dw);
        if (s == 64'd0) s = 64'd1;
        for (int i = 0; i < k; i++) begin
            fb = 1'b0;
            foreach (taps[j]) fb ^= s[taps[j]];
            s = (s >> 1) | (64'(fb) << (dw - 1));
        end
        return s;
    endfunction

    task automatic run_burst(input logic [1:0] m, input int n, input logic [15:0] c,
                             input int ready_pct, input int stop_after, input int stop_pct);
        int          k = 0;
        int          cyc = 0;
        logic [63:0] xs = 64'd0;
        logic        acc, stp;
        bit          ended = 0;
        start = 1'b1; mode = m; len = LW'(n); cval = c; stop = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; len = LW'($urandom); cval = DW'($urandom);
        check("start_valid", valid, 1);
        check("start_busy", busy, 1);
        check("start_cnt", cnt, 0);
        check("start_csum", csum, 0);
        while (!ended) begin
            check("data", data, ref_word(DW, m, k, 64'(c)));
            if (pat.size() > 0) acc = (pat.pop_front() != 0);
            else                acc = ($urandom_range(99) < ready_pct);
            stp = (stop_after > 0 && k == stop_after - 1 && acc) ||
                  (stop_pct > 0 && $urandom_range(99) < stop_pct) || (cyc >= 500);
            ready = acc; stop = stp; start = 1'($urandom_range(1));
            @(posedge clk); #1;
            if (acc) begin
                xs ^= ref_word(DW, m, k, 64'(c));
                k++;
            end
            cyc++;
            ended = stp || (acc && n != 0 && k == n);
            if (!ended) begin
                check("run_valid", valid, 1);
                check("run_done", done, 0);
            end
        end
        ready = 1'($urandom_range(1)); stop = 1'b0; start = 1'b1;
        check("end_valid", valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_cnt", cnt, 64'(unsigned'(k)) & mask_of(LW));
`ifdef MINI_STIM_CHECKSUM_EN
        check("end_csum", csum, xs);
`else
        check("end_csum", csum, 0);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_done", done, 0);
        check("idle_valid", valid, 0);
        check("idle_cnt_hold", cnt, 64'(unsigned'(k)) & mask_of(LW));
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic run8(input logic [1:0] m, input int n, input int stop_after);
        int   k = 0;
        bit   ended = 0;
        logic stp;
        start8 = 1'b1; mode8 = m; len8 = LW8'(n); cval8 = 8'h5A; stop8 = 1'b0; ready8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("d8_start_valid", valid8, 1);
        while (!ended) begin
            check("d8_data", data8, ref_word(DW8, m, k, 64'h5A));
            stp = (stop_after > 0 && k == stop_after - 1) || (k >= 200);
            stop8 = stp;
            @(posedge clk); #1;
            k++;
            ended = stp || (n != 0 && k == n);
        end
        stop8 = 1'b0;
        check("d8_end_done", done8, 1);
        check("d8_end_valid", valid8, 0);
        check("d8_end_cnt", cnt8, 64'(unsigned'(k)) & mask_of(LW8));
        @(posedge clk); #1;
        check("d8_idle_done", done8, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; ready = 1'b0; mode = 2'd0; len = '0; cval = '0;
        start8 = 1'b0; stop8 = 1'b0; ready8 = 1'b0; mode8 = 2'd0; len8 = '0; cval8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cnt, 0);
        check("rst_csum", csum, 0);
        check("rst8_valid", valid8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(2'd0, 3, 16'h0000, 100, 0, 0);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        run_burst(2'd1, 4, 16'h0000, 100, 0, 0);
        run8(2'd2, 10, 0);
        run_burst(2'd3, 0, 16'hBEEF, 100, 5, 0);
        run_burst(2'd1, 5, 16'h0000, 100, 0, 0);
        run8(2'd2, 0, 20);

        for (int b = 0; b < 12; b++) begin
            int n;
            n = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(12, 1));
            run_burst(2'($urandom_range(3)), n, 16'($urandom), 60, 0, (n == 0) ? 10 : 3);
        end

        // Asynchronous reset in the middle of an LFSR burst.
        start = 1'b1; mode = 2'd0; len = '0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_data", data, 0);
        check("arst_busy", busy, 0);
        check("arst_cnt", cnt, 0);
        check("arst_csum", csum, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle_done", done, 0);
        run_burst(2'd0, 3, 16'h0000, 100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mini_stim_gen.md
# mini_stim_gen

Parametrised, synthesizable stimulus generator. It produces bursts of DW-bit data words over a valid/ready stream interface, in one of four runtime-selectable patterns: LFSR pseudo-random, incrementing counter, walking-one or constant. It replaces ad-hoc random/counter drivers in front of the mini datapath, and it serves both as an on-chip BIST source and as a bench driver for `i_din`.

## Interface
- `DW`, 16: data width; LFSR mode supports only 8, 16 and 32. Any other DW with LFSR logic present is an elaboration error.
- `LW`, 16: width of burst length and beat counter.
- `SEED`, 16'hACE1: LFSR seed, truncated to DW; a value of 0 is replaced by 1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start a burst; sampled only in IDLE.
- `i_stop`  in  1  terminate a running burst.
- `i_mode`  in  2  0 LFSR, 1 counter, 2 walking-one, 3 constant; latched at start.
- `i_len`  in  LW  beats per burst; 0 = continuous; latched at start.
- `i_const`  in  DW  constant value for mode 3; latched at start.
- `o_valid`  out  1  data valid.
- `i_ready`  in  1  sink ready.
- `o_data`  out  DW  stimulus word.
- `o_busy`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse at burst end.
- `o_cnt`  out  LW  accepted beats in current/last burst.
- `o_csum`  out  DW  XOR checksum of accepted beats (see Configuration).

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE → RUN** on `i_start`:
  - latch `i_mode`, `i_len` and `i_const`;
  - clear `o_cnt` and `o_csum`;
  - load the generator: LFSR = SEED, counter = 0, walking-one = 1, constant = `i_const`.
- **RUN**:
  - `o_valid`=1 and `o_data` = current generator value.
  - A beat is accepted when `o_valid & i_ready`. On acceptance the generator advances, `o_cnt` increments and `o_csum` ^= `o_data`.
  - `i_start` is ignored.
- **RUN → DONE** on either condition:
  - accepted beat with `i_len`≠0 and `o_cnt`+1 == `i_len`;
  - `i_stop`=1. A beat accepted in the same cycle still counts.
- **DONE → IDLE** unconditionally after one cycle. `o_done`=1 only in DONE, and `i_start` is ignored in DONE.
- Generator update rules:
  - LFSR: Fibonacci right-shift. fb = XOR of taps; next = {fb, cur[DW-1:1]}. Taps (bit positions): DW=8: 0,2,3,4; DW=16: 0,2,3,5; DW=32: 0,10,30,31.
  - Counter: +1 modulo 2^DW.
  - Walking-one: rotate left, so MSB wraps to bit 0.
  - Constant: unchanged.
- In continuous mode (`i_len`=0), `o_cnt` wraps modulo 2^LW and the burst ends only on `i_stop`.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_busy`=0, `o_done`=0, `o_cnt`=0, `o_csum`=0. State is IDLE.
- All outputs are registered.
- `i_start` sampled at edge t gives `o_valid`=1 with the first word from edge t+1.
- While `o_valid`=1 and `i_ready`=0, `o_data` holds stable; `o_valid` never drops mid-burst except by end condition.
- After the last accepted beat (edge t): at t+1, `o_valid`=0 and `o_done`=1; at t+2, IDLE. The earliest next start is sampled at t+2, giving a minimum of 2 idle cycles between bursts.
- `o_cnt` and `o_csum` hold their values after DONE until the next start.
- Asserting `rst_n` mid-burst clears state immediately. There is no done pulse, and the next burst restarts from SEED.

## Configuration
- Macro: `MINI_STIM_CHECKSUM_EN`.
- Defined: `o_csum` accumulates the XOR of accepted beats as specified above.
- Undefined: the checksum register is removed and `o_csum` is tied to 0. The port list is unchanged.

## Test plan
- DW=16, SEED=16'hACE1, mode 0, len 3, `i_ready`=1 → `o_data` 16'hACE1, 16'h5670, 16'hAB38; `o_done` pulse one cycle after the third beat; `o_cnt`=3.
- Mode 1, len 4, `i_ready` pattern 1,0,0,1,1,0,1 → accepted data 0,1,2,3; `o_data` held through stalls; `o_cnt`=4.
- DW=8, mode 2, len 10, `i_ready`=1 → 01,02,04,08,10,20,40,80,01,02.
- Mode 3, `i_const`=16'hBEEF, len 0, `i_stop` in the cycle of the 5th acceptance → 5 beats of BEEF, `o_cnt`=5, `o_done` pulse; `i_start` during RUN and DONE ignored.
- `rst_n` low during a mode 0 burst → all outputs 0 asynchronously, no `o_done`; a restart emits 16'hACE1 first.
- With `MINI_STIM_CHECKSUM_EN`, mode 1, len 5 → `o_csum`=16'h0004. Without the macro → `o_csum`=0.
